// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, one outstanding imem request, 2-entry IF queue, redirect/flush.
// Response lands in the queue on the transfer edge; stall only blocks pops, so a full queue holds off new requests.
module pc_fetch_unit #(
    parameter int unsigned       PC_W     = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
    parameter int unsigned       PC_STEP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_src,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               flush,
    output logic [15:0]        redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               req_q, req_d;
    logic               flush_q, flush_d;
    logic [15:0]        rcnt_q, rcnt_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [PC_W-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INSTR_W-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic               xfer, push, pop;

    always_comb begin
        xfer    = req_q & imem_ready;
        pop     = (cnt_q != 2'd0) & ~stall;
        push    = xfer & (state_q == ST_RUN) & ~pc_src;

        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        flush_d = 1'b0;
        rcnt_d  = rcnt_q;
        cnt_d   = cnt_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        ins0_d  = ins0_q;
        ins1_d  = ins1_q;

        if (pc_src) begin
            pc_d    = branch_target;
            flush_d = 1'b1;
            cnt_d   = 2'd0;
            if (rcnt_q != 16'hFFFF) begin
                rcnt_d = rcnt_q + 16'd1;
            end
        end else begin
            if (push) begin
                pc_d = pc_q + STEP;
            end
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        pc0_d  = pc_q;
                        ins0_d = imem_rdata;
                    end else begin
                        pc1_d  = pc_q;
                        ins1_d = imem_rdata;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    pc0_d  = pc1_q;
                    ins0_d = ins1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = pc_q;
                        ins1_d = imem_rdata;
                    end else begin
                        pc0_d  = pc_q;
                        ins0_d = imem_rdata;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_BOOT:    state_d = ST_RUN;
            ST_RUN:     if (pc_src && req_q && !imem_ready) state_d = ST_DISCARD;
            ST_DISCARD: if (imem_ready) state_d = ST_RUN;
            default:    state_d = ST_BOOT;
        endcase

        // A request is never withdrawn; a new one is decided from next-cycle occupancy so its response always has a slot.
        if (req_q) begin
            req_d = ~imem_ready;
        end else begin
            req_d  = (state_q != ST_DISCARD) && (cnt_d != 2'd2);
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
            rcnt_q  <= 16'd0;
            cnt_q   <= 2'd0;
            pc0_q   <= '0;
            pc1_q   <= '0;
            ins0_q  <= '0;
            ins1_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            flush_q <= flush_d;
            rcnt_q  <= rcnt_d;
            cnt_q   <= cnt_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            ins0_q  <= ins0_d;
            ins1_q  <= ins1_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign if_valid       = (cnt_q != 2'd0);
    assign if_pc          = pc0_q;
    assign if_instr       = ins0_q;
    assign flush          = flush_q;
    assign redirect_count = rcnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic, checked against a queue-based fetch model.
module tb_pc_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, pc_src, stall, imem_ready;
    logic [15:0] branch_target;
    logic        imem_req, if_valid, flush;
    logic [15:0] imem_addr, imem_rdata, if_pc, if_instr, redirect_count;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_rdata = mem_fn(imem_addr);

    pc_fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(RESET_PC), .PC_STEP(2)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
        .redirect_count(redirect_count)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] popped[$];
    logic [15:0] exp_fetch;
    logic [15:0] rc_m;
    bit          stale;
    int          n_checks = 0;
    int          n_fail   = 0;

    // One clock edge: capture what the edge sees, advance the model, then compare every observable output.
    task automatic step();
        logic        was_req, was_xfer, was_pop, was_redir;
        logic [15:0] was_addr, was_head, was_tgt;
        was_req   = imem_req;
        was_addr  = imem_addr;
        was_xfer  = imem_req && imem_ready;
        was_pop   = if_valid && !stall;
        was_redir = pc_src;
        was_tgt   = branch_target;
        was_head  = if_pc;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            stale     = 1'b0;
            exp_fetch = RESET_PC;
            rc_m      = 16'd0;
            n_checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0 || flush !== 1'b0 || redirect_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_state t=%0t req=%b valid=%b flush=%b rc=%h required all zero",
                         $time, imem_req, if_valid, flush, redirect_count);
            end
        end else begin
            if (was_redir) begin
                stale = was_req && !was_xfer;
                mq.delete();
                exp_fetch = was_tgt;
                if (rc_m != 16'hFFFF) rc_m = rc_m + 16'd1;
            end else begin
                if (was_pop && mq.size() != 0) begin
                    popped.push_back(was_head);
                    void'(mq.pop_front());
                end
                if (was_xfer) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        mq.push_back('{pc: exp_fetch, instr: mem_fn(exp_fetch)});
                        exp_fetch = exp_fetch + 16'd2;
                    end
                end
            end
            n_checks++;
            if (flush !== was_redir) begin
                n_fail++;
                $display("FAIL flush t=%0t got=%b exp=%b", $time, flush, was_redir);
            end
            n_checks++;
            if (redirect_count !== rc_m) begin
                n_fail++;
                $display("FAIL redirect_count t=%0t got=%h exp=%h", $time, redirect_count, rc_m);
            end
            n_checks++;
            if (if_valid !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL if_valid t=%0t got=%b exp_entries=%0d", $time, if_valid, mq.size());
            end
            if (mq.size() != 0 && if_valid === 1'b1) begin
                n_checks++;
                if (if_pc !== mq[0].pc || if_instr !== mq[0].instr) begin
                    n_fail++;
                    $display("FAIL queue_head t=%0t got pc=%h instr=%h exp pc=%h instr=%h",
                             $time, if_pc, if_instr, mq[0].pc, mq[0].instr);
                end
            end
            if (was_req && !was_xfer) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== was_addr) begin
                    n_fail++;
                    $display("FAIL req_hold t=%0t got req=%b addr=%h exp req=1 addr=%h",
                             $time, imem_req, imem_addr, was_addr);
                end
            end
            if (was_xfer) begin
                n_checks++;
                if (imem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_gap t=%0t got req=%b exp=0", $time, imem_req);
                end
            end
            if (!was_req && imem_req === 1'b1 && !stale) begin
                n_checks++;
                if (imem_addr !== exp_fetch || mq.size() >= 2) begin
                    n_fail++;
                    $display("FAIL issue t=%0t got addr=%h entries=%0d exp addr=%h entries<2",
                             $time, imem_addr, mq.size(), exp_fetch);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_src = 1'b0; stall = 1'b0; imem_ready = 1'b1; branch_target = 16'h0;
        step();
        step();
        rst = 1'b0;
        popped.delete();
    endtask

    task automatic wait_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (imem_req === 1'b1) ok = 1'b1;
            else step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        n_checks++;
        if (imem_req !== 1'b0 || redirect_count !== 16'd0) begin
            n_fail++;
            $display("FAIL boot_idle got req=%b rc=%h exp req=0 rc=0", imem_req, redirect_count);
        end
        wait_req(5, ok);
        n_checks++;
        if (!ok || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL boot_first_addr got ok=%b addr=%h exp addr=%h", ok, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_straight();
        do_reset();
        for (int i = 0; i < 40 && popped.size() < 4; i++) step();
        n_checks++;
        if (popped.size() < 4) begin
            n_fail++;
            $display("FAIL straight_progress got pops=%0d exp>=4", popped.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (popped[i] !== 16'(2 * i)) begin
                    n_fail++;
                    $display("FAIL straight_pc[%0d] got=%h exp=%h", i, popped[i], 16'(2 * i));
                end
            end
        end
    endtask

    task automatic test_stall_fill();
        logic [15:0] head;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (mq.size() != 2 || imem_req !== 1'b0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full got entries=%0d req=%b valid=%b exp 2/0/1", mq.size(), imem_req, if_valid);
        end
        head = if_pc;
        stall = 1'b0;
        popped.delete();
        for (int i = 0; i < 30 && popped.size() < 5; i++) step();
        n_checks++;
        if (popped.size() < 5) begin
            n_fail++;
            $display("FAIL stall_release got pops=%0d exp>=5", popped.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (popped[i] !== head + 16'(2 * i)) begin
                    n_fail++;
                    $display("FAIL stall_order[%0d] got=%h exp=%h", i, popped[i], head + 16'(2 * i));
                end
            end
        end
    endtask

    task automatic test_redirect_pending();
        bit ok;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            imem_ready = !(imem_req === 1'b1 && imem_addr == 16'h0008);
            if (!imem_ready) break;
            step();
        end
        step();
        pc_src = 1'b1; branch_target = 16'h0040;
        step();
        n_checks++;
        if (flush !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_flush_hi got=%b exp=1", flush);
        end
        pc_src = 1'b0;
        step();
        n_checks++;
        if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
            n_fail++;
            $display("FAIL redir_discard got flush=%b req=%b addr=%h exp 0/1/0008", flush, imem_req, imem_addr);
        end
        step();
        imem_ready = 1'b1;
        step();
        popped.delete();
        wait_req(6, ok);
        n_checks++;
        if (!ok || imem_addr !== 16'h0040 || redirect_count !== 16'd1) begin
            n_fail++;
            $display("FAIL redir_target got ok=%b addr=%h rc=%h exp addr=0040 rc=1", ok, imem_addr, redirect_count);
        end
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (popped.size() == 0 || popped[0] !== 16'h0040) begin
            n_fail++;
            $display("FAIL redir_first_pop got n=%0d first=%h exp first=0040", popped.size(),
                     popped.size() != 0 ? popped[0] : 16'hxxxx);
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (imem_req === 1'b1 && imem_addr == 16'h000A) break;
            step();
        end
        pc_src = 1'b1; branch_target = 16'h0100;
        step();
        pc_src = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || flush !== 1'b1 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_drop got req=%b flush=%b valid=%b exp 0/1/0", imem_req, flush, if_valid);
        end
        wait_req(4, ok);
        n_checks++;
        if (!ok || imem_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL same_cycle_target got ok=%b addr=%h exp 0100", ok, imem_addr);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        pc_src = 1'b1; branch_target = 16'hFFFE;
        step();
        pc_src = 1'b0;
        wait_req(4, ok);
        n_checks++;
        if (!ok || imem_addr !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wrap_pre got ok=%b addr=%h exp FFFE", ok, imem_addr);
        end
        step();
        wait_req(4, ok);
        n_checks++;
        if (!ok || imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_addr got ok=%b addr=%h exp 0000", ok, imem_addr);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        pc_src = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            branch_target = 16'($urandom) & 16'hFFFE;
            step();
        end
        n_checks++;
        if (redirect_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_preload got=%h exp=FFFF", redirect_count);
        end
        step();
        pc_src = 1'b0;
        n_checks++;
        if (redirect_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold got=%h exp=FFFF", redirect_count);
        end
    endtask

    task automatic test_reset_discard();
        bit ok;
        do_reset();
        imem_ready = 1'b0;
        wait_req(6, ok);
        pc_src = 1'b1; branch_target = 16'h0200;
        step();
        pc_src = 1'b0;
        step();
        n_checks++;
        if (!ok || imem_req !== 1'b1 || imem_addr === 16'h0200) begin
            n_fail++;
            $display("FAIL rd_in_discard got ok=%b req=%b addr=%h exp stale request held", ok, imem_req, imem_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b1;
        n_checks++;
        if (if_valid !== 1'b0 || flush !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_after_rst got valid=%b flush=%b req=%b exp 0/0/0", if_valid, flush, imem_req);
        end
        wait_req(5, ok);
        n_checks++;
        if (!ok || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rd_boot_addr got ok=%b addr=%h exp %h", ok, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        int pops_before;
        do_reset();
        pops_before = 0;
        for (int i = 0; i < 3000; i++) begin
            stall         = ($urandom % 3) == 0;
            imem_ready    = ($urandom % 2) == 0;
            pc_src        = ($urandom % 16) == 0;
            branch_target = 16'($urandom) & 16'hFFFE;
            rst           = ($urandom % 500) == 0;
            step();
        end
        rst = 1'b0; pc_src = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        pops_before = popped.size();
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (popped.size() <= pops_before) begin
            n_fail++;
            $display("FAIL random_liveness got pops=%0d exp>%0d", popped.size(), pops_before);
        end
    endtask

    initial begin
        rst = 1'b1; pc_src = 1'b0; stall = 1'b0; imem_ready = 1'b0; branch_target = 16'h0;
        exp_fetch = RESET_PC; rc_m = 16'd0; stale = 1'b0;
        test_reset();
        test_straight();
        test_stall_fill();
        test_redirect_pending();
        test_same_cycle();
        test_wrap();
        test_reset_discard();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
